// File: rtl/aes_shift_rows_pipe.sv
// ShiftRows / InvShiftRows for Rijndael Nb = 4, 6, 8, followed by an elastic valid/ready pipeline.
// The permutation is pure wiring on the input side; every stage is fully registered.
module aes_shift_rows_pipe #(
  parameter int unsigned NB     = 4,
  parameter int unsigned STAGES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inValid,
  output logic              inReady,
  input  logic              inInverse,
  input  logic [32*NB-1:0]  inData,
  output logic              outValid,
  input  logic              outReady,
  output logic [32*NB-1:0]  outData,
  output logic              outInverse,
  output logic              busy
);

  localparam int unsigned W = 32 * NB;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("aes_shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("aes_shift_rows_pipe: STAGES must be in 1..4");
  end

  // Byte k = 4*c + r sits at bits [W-1-8k -: 8]; rows 2 and 3 shift one further when NB = 8.
  logic [W-1:0] perm;

  for (genvar c = 0; c < int'(NB); c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int Shift  = (NB == 8 && r >= 2) ? r + 1 : r;
      localparam int FwdSrc = (c + Shift) % int'(NB);
      localparam int InvSrc = (c + int'(NB) - Shift) % int'(NB);
      localparam int Dst    = 4 * c + r;
      assign perm[W-1-8*Dst -: 8] = inInverse ? inData[W-1-8*(4*InvSrc+r) -: 8]
                                              : inData[W-1-8*(4*FwdSrc+r) -: 8];
    end
  end

  logic [W-1:0]        data_q   [STAGES];
  logic [W-1:0]        src_data [STAGES];
  logic [STAGES-1:0]   valid_q;
  logic [STAGES-1:0]   inv_q;
  logic [STAGES-1:0]   src_valid;
  logic [STAGES-1:0]   src_inv;
  logic [STAGES-1:0]   adv;

  for (genvar i = 0; i < int'(STAGES); i++) begin : g_stage
    if (i == 0) begin : g_head
      assign src_valid[i] = inValid;
      assign src_inv[i]   = inInverse;
      assign src_data[i]  = perm;
    end else begin : g_body
      assign src_valid[i] = valid_q[i-1];
      assign src_inv[i]   = inv_q[i-1];
      assign src_data[i]  = data_q[i-1];
    end
    // Stage i moves unless it and every stage downstream is full and the sink is stalled.
    assign adv[i] = outReady || !(&valid_q[STAGES-1:i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      inv_q   <= '0;
      for (int i = 0; i < int'(STAGES); i++) begin
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(STAGES); i++) begin
        if (adv[i]) begin
          valid_q[i] <= src_valid[i];
          if (src_valid[i]) begin
            data_q[i] <= src_data[i];
            inv_q[i]  <= src_inv[i];
          end
        end
      end
    end
  end

  assign inReady    = adv[0];
  assign outValid   = valid_q[STAGES-1];
  assign outData    = data_q[STAGES-1];
  assign outInverse = inv_q[STAGES-1];
  assign busy       = |valid_q;

endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// Directed bench for aes_shift_rows_pipe: NB=4/STAGES=1, NB=8/STAGES=3 and NB=4/STAGES=4 instances.
module tb_aes_shift_rows_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         a_iv, a_ir, a_inv, a_ov, a_or, a_oinv, a_busy;
  logic [127:0] a_d, a_od;
  logic         b_iv, b_ir, b_inv, b_ov, b_or, b_oinv, b_busy;
  logic [255:0] b_d, b_od;
  logic         c_iv, c_ir, c_inv, c_ov, c_or, c_oinv, c_busy;
  logic [127:0] c_d, c_od;

  aes_shift_rows_pipe #(.NB(4), .STAGES(1)) dut_a (
    .clk(clk), .rst(rst), .inValid(a_iv), .inReady(a_ir), .inInverse(a_inv), .inData(a_d),
    .outValid(a_ov), .outReady(a_or), .outData(a_od), .outInverse(a_oinv), .busy(a_busy)
  );
  aes_shift_rows_pipe #(.NB(8), .STAGES(3)) dut_b (
    .clk(clk), .rst(rst), .inValid(b_iv), .inReady(b_ir), .inInverse(b_inv), .inData(b_d),
    .outValid(b_ov), .outReady(b_or), .outData(b_od), .outInverse(b_oinv), .busy(b_busy)
  );
  aes_shift_rows_pipe #(.NB(4), .STAGES(4)) dut_c (
    .clk(clk), .rst(rst), .inValid(c_iv), .inReady(c_ir), .inInverse(c_inv), .inData(c_d),
    .outValid(c_ov), .outReady(c_or), .outData(c_od), .outInverse(c_oinv), .busy(c_busy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // State as a row x column byte matrix, rotated row by row.
  function automatic logic [255:0] ref_perm(input int nb, input logic [255:0] d, input logic inv);
    logic [7:0]   st [4][8];
    logic [255:0] res;
    int           sh;
    int           src;
    res = '0;
    for (int k = 0; k < 4 * nb; k++) st[k % 4][k / 4] = d[32*nb-1-8*k -: 8];
    for (int row = 0; row < 4; row++) begin
      sh = (nb == 8 && row > 1) ? row + 1 : row;
      for (int col = 0; col < nb; col++) begin
        src = inv ? (col - sh + nb) % nb : (col + sh) % nb;
        res[32*nb-1-8*(4*col+row) -: 8] = st[row][src];
      end
    end
    return res;
  endfunction

  typedef struct {
    logic         inv;
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;

  task automatic run_stream(input int n, input int stall_at, input int stall_len);
    logic [127:0] sd [32];
    logic         si [32];
    logic [127:0] prev_d;
    logic         prev_inv;
    logic         prev_stall;
    logic         drop_seen;
    logic         fin, fout;
    int           sent, recv, cyc;
    sent = 0; recv = 0; cyc = 0;
    prev_stall = 1'b0; drop_seen = 1'b0; prev_d = '0; prev_inv = 1'b0;
    for (int k = 0; k < n; k++) begin
      sd[k] = {$urandom, $urandom, $urandom, $urandom};
      si[k] = (k % 2) == 1;
    end
    while (recv < n && cyc < 300) begin
      c_or  = !(cyc >= stall_at && cyc < stall_at + stall_len);
      c_iv  = sent < n;
      c_d   = (sent < n) ? sd[sent] : {$urandom, $urandom, $urandom, $urandom};
      c_inv = (sent < n) ? si[sent] : 1'b1;
      @(negedge clk);
      check("c_ready", c_ir, (sent - recv < 4) || c_or);
      check("c_busy", c_busy, sent != recv);
      if (prev_stall) begin
        check("c_stall_valid", c_ov, 1'b1);
        check("c_stall_data", c_od, prev_d);
        check("c_stall_inv", c_oinv, prev_inv);
      end
      if (stall_len == 0 && cyc >= 4 && cyc < n + 4) check("c_thru_valid", c_ov, 1'b1);
      if (!c_ir && sent - recv == 4) drop_seen = 1'b1;
      fin  = c_iv && c_ir;
      fout = c_ov && c_or;
      if (fout) begin
        check("c_out_data", c_od, ref_perm(4, {128'd0, sd[recv]}, si[recv]));
        check("c_out_inv", c_oinv, si[recv]);
        recv++;
      end
      prev_stall = c_ov && !c_or;
      prev_d     = c_od;
      prev_inv   = c_oinv;
      if (fin) sent++;
      step();
      cyc++;
    end
    c_iv = 1'b0;
    c_or = 1'b1;
    check("c_count", recv, n);
    check("c_ready_drop", drop_seen, stall_len > 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    vec_t         tbl [4];
    logic [127:0] x, y;
    logic [255:0] bd;

    tbl[0] = '{1'b0, 128'h000102030405060708090a0b0c0d0e0f, 128'h00050a0f04090e03080d02070c01060b};
    tbl[1] = '{1'b1, 128'h000102030405060708090a0b0c0d0e0f, 128'h000d0a0704010e0b0805020f0c090603};
    tbl[2] = '{1'b0, 128'h101112131415161718191a1b1c1d1e1f, 128'h10151a1f14191e13181d12171c11161b};
    tbl[3] = '{1'b1, 128'h101112131415161718191a1b1c1d1e1f, 128'h101d1a1714111e1b1815121f1c191613};

    rst = 1'b1;
    a_iv = 1'b0; a_inv = 1'b0; a_d = '0; a_or = 1'b1;
    b_iv = 1'b0; b_inv = 1'b0; b_d = '0; b_or = 1'b1;
    c_iv = 1'b0; c_inv = 1'b0; c_d = '0; c_or = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_a_valid", a_ov, 1'b0);
    check("rst_a_busy", a_busy, 1'b0);
    check("rst_a_data", a_od, 128'd0);
    check("rst_a_inv", a_oinv, 1'b0);
    check("rst_b_data", b_od, 256'd0);
    check("rst_c_valid", c_ov, 1'b0);
    check("rst_a_ready", a_ir, 1'b1);
    check("rst_b_ready", b_ir, 1'b1);
    check("rst_c_ready", c_ir, 1'b1);

    // Table vectors back to back through the single-stage instance.
    for (int i = 0; i < 4; i++) begin
      a_iv = 1'b1; a_inv = tbl[i].inv; a_d = tbl[i].din;
      step();
      check("tbl_valid", a_ov, 1'b1);
      check("tbl_data", a_od, tbl[i].dout);
      check("tbl_inv", a_oinv, tbl[i].inv);
    end
    a_iv = 1'b0; a_d = '1; a_inv = 1'b1;
    step();
    check("idle_a_valid", a_ov, 1'b0);
    check("idle_a_busy", a_busy, 1'b0);

    // Forward then inverse round trip.
    a_iv = 1'b1;
    for (int it = 0; it < 1000; it++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      a_inv = 1'b0; a_d = x;
      step();
      y = a_od;
      check("rt_fwd", y, ref_perm(4, {128'd0, x}, 1'b0));
      a_inv = 1'b1; a_d = y;
      step();
      check("rt_back", a_od, x);
    end
    a_iv = 1'b0;
    step();

    // NB=8, three-cycle latency, forward then inverse.
    for (int k = 0; k < 32; k++) bd[255-8*k -: 8] = 8'(k);
    for (int m = 0; m < 2; m++) begin
      b_iv = 1'b1; b_inv = (m == 1); b_d = bd;
      step();
      b_iv = 1'b0; b_d = '1; b_inv = 1'b0;
      check("b_lat1", b_ov, 1'b0);
      step();
      check("b_lat2", b_ov, 1'b0);
      step();
      check("b_lat3", b_ov, 1'b1);
      check("b_data", b_od, ref_perm(8, bd, m == 1));
      check("b_head", b_od[255:224], (m == 1) ? 32'h001d1613 : 32'h00050e13);
      check("b_inv", b_oinv, m == 1);
      step();
      check("b_drain", b_ov, 1'b0);
    end

    // Four-stage stream with a mid-stream stall, then a stall-free stream.
    run_stream(20, 8, 6);
    run_stream(30, 0, 0);

    // Reset with three transactions in flight.
    c_or = 1'b1;
    for (int k = 0; k < 3; k++) begin
      c_iv = 1'b1; c_inv = 1'b1; c_d = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    c_iv = 1'b0;
    check("flight_busy", c_busy, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_valid", c_ov, 1'b0);
    check("mid_rst_busy", c_busy, 1'b0);
    check("mid_rst_data", c_od, 128'd0);
    check("mid_rst_inv", c_oinv, 1'b0);
    for (int k = 0; k < 8; k++) begin
      step();
      check("post_rst_valid", c_ov, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes_shift_rows_pipe.md
Name: aes_shift_rows_pipe

Overview:
- Parametrised, pipelined ShiftRows / InvShiftRows stage for the round datapath.
- Supports the Rijndael block widths Nb = 4, 6 and 8 columns, selectable at elaboration.
- Direction is selected per transaction.
- Registered, elastic valid/ready pipeline of configurable depth, so it drops between the SubBytes and MixColumns stages without combinational paths through the permutation.

Parameters:
- NB, 4, number of state columns; legal values 4, 6, 8; data width W = 32*NB.
- STAGES, 1, number of register stages; legal values 1..4; latency in cycles.

Ports:
- clk  input  1  clock, all logic rising-edge.
- rst  input  1  synchronous active-high reset.
- inValid  input  1  upstream transaction valid.
- inReady  output  1  block can accept in this cycle.
- inInverse  input  1  0 = ShiftRows, 1 = InvShiftRows; sampled with inData.
- inData  input  W  input state.
- outValid  output  1  outData valid.
- outReady  input  1  downstream accepts.
- outData  output  W  permuted state.
- outInverse  output  1  inInverse carried alongside the data.
- busy  output  1  any stage holds valid data.

Behaviour:
- Byte indexing:
  - Byte k occupies bits [W-1-8k : W-8-8k], so byte 0 is at the MSBs.
  - Byte k is column c = k/4, row r = k%4.
- Row shift s(r):
  - NB = 4 or 6: s = 0, 1, 2, 3.
  - NB = 8: s = 0, 1, 3, 4.
- Permutation:
  - Forward: out[r][c] = in[r][(c + s(r)) mod NB].
  - Inverse: out[r][c] = in[r][(c − s(r)) mod NB].
  - Permutation is pure wiring, applied combinationally on inData before stage 0.
  - Each stage stores data W bits, inverse 1 bit, valid 1 bit.
- Pipeline:
  - Stage i advances when v[i] = 0 or stage i+1 advances.
  - The last stage advances when outReady = 1.
  - inReady = stage-0-advance. This is a combinational ready chain; no bubbles are required.
  - Transfer in: inValid && inReady. Transfer out: outValid && outReady.
- Latency and throughput:
  - Exactly STAGES cycles from input transfer to outValid when unstalled.
  - Full throughput of one transaction per cycle sustained.
- Stall and order:
  - outValid = 1 with outReady = 0 holds outData and outInverse stable until accepted.
  - No reordering, no loss, no duplication.
- Simultaneous events:
  - A full pipeline with outReady = 1 accepts a new input in the same cycle.
  - A full pipeline with outReady = 0 deasserts inReady.
- Unaccepted input: inInverse and inData are ignored when no input transfer occurs.
- busy = OR of all stage valid bits.
- Reset:
  - All valid bits clear. outValid = 0, busy = 0, outData = 0, outInverse = 0.
  - inReady = 1 in the cycle after reset deasserts.
  - Reset mid-operation discards all in-flight data; nothing is emitted afterwards.
- Illegal parameters: NB outside {4,6,8} or STAGES outside 1..4 must fail elaboration.

Test Plan:
- NB=4, STAGES=1, forward, inData = 0x000102030405060708090a0b0c0d0e0f → one cycle later outData = 0x00050a0f04090e03080d02070c01060b, outInverse = 0.
- NB=4, inverse, same inData → outData = 0x000d0a07040 10e0b08050 20f0c090603 written contiguously as 0x000d0a0704010e0b0805020f0c090603. A forward-then-inverse round trip of 1000 random states returns the original.
- NB=8, STAGES=3, forward, inData bytes 0x00..0x1f ascending → out bytes 0..3 = 00 05 0e 13, checked against the reference model; output appears exactly 3 cycles after acceptance.
- STAGES=4, back-to-back stream of 20 states with alternating inInverse and outReady held low for 6 cycles mid-stream:
  - inReady drops once 4 are held.
  - Outputs stay stable while stalled.
  - Order and mode tags are preserved; 20 outputs total.
- Full pipeline with outReady = 1 and inValid = 1 every cycle → one output per cycle, inReady never deasserts.
- Assert rst for one cycle with 3 transactions in flight → next cycle outValid = 0, busy = 0, outData = 0; none of the 3 ever appear on the output.
